// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: word type, fetch FSM states,
// reset PC and sequential step.
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

    localparam word_t FETCH_RESET_PC = 32'h0000_3000;
    localparam word_t FETCH_PC_STEP  = 32'd4;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, sequential increment, and
// aligned redirect load (load wins over increment).
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = FETCH_RESET_PC,
    parameter word_t PC_STEP  = FETCH_PC_STEP
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load,
    input  word_t load_addr,
    output word_t pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= align_word(load_addr);
        else if (inc)
            pc <= pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Handshaked instruction-fetch loop: one imem request in flight, returned
// word buffered for decode, execute redirects squash whatever is in flight.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = FETCH_RESET_PC,
    parameter word_t PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    fetch_state_e state, state_n;
    logic         discard, discard_n;
    logic         inst_valid_n;
    word_t        inst_data_n, inst_pc_n;
    logic         pc_inc, pc_load;
    word_t        pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (redirect_target),
        .pc        (pc)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            discard    <= discard_n;
            inst_valid <= inst_valid_n;
            inst_data  <= inst_data_n;
            inst_pc    <= inst_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        discard_n    = discard;
        inst_valid_n = inst_valid;
        inst_data_n  = inst_data;
        inst_pc_n    = inst_pc;
        pc_inc       = 1'b0;
        pc_load      = redirect_valid;

        unique case (state)
            IDLE: state_n = REQ;

            // A redirect racing the handshake leaves a response in flight
            // that must be swallowed when it lands.
            REQ: begin
                if (imem_req_ready) begin
                    state_n   = WAIT;
                    discard_n = redirect_valid;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        state_n   = REQ;
                        discard_n = 1'b0;
                    end else begin
                        discard_n = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard) begin
                        discard_n = 1'b0;
                        state_n   = REQ;
                    end else begin
                        inst_valid_n = 1'b1;
                        inst_data_n  = imem_rsp_data;
                        inst_pc_n    = pc;
                        state_n      = OUT;
                    end
                end
            end

            // PC advances only on a plain consume; a redirect already loads it.
            OUT: begin
                if (redirect_valid || inst_ready) begin
                    inst_valid_n = 1'b0;
                    pc_inc       = !redirect_valid;
                    state_n      = REQ;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: imem responder model, expected
// request/instruction queues checked every cycle, one task per scenario.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] exp_req[$];
    inst_t       exp_inst[$];
    rsp_t        rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_lat = 1;
    logic [31:0] salt = '0;
    logic        acc;
    logic [31:0] acc_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push_fetch(input logic [31:0] a, input bit deliver);
        inst_t e;
        exp_req.push_back(a);
        if (deliver) begin
            e.pc   = a;
            e.data = mem_word(a);
            exp_inst.push_back(e);
        end
    endtask

    // One clock: scoreboard sampling on the falling edge, imem responder
    // update just after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (acc) begin
            logic [31:0] e;
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got addr %h, no request expected", acc_addr);
            end else begin
                e = exp_req.pop_front();
                if (acc_addr !== e) begin
                    errors++;
                    $display("FAIL req_addr: got %h, expected %h", acc_addr, e);
                end
            end
        end
        if (inst_valid && inst_ready) begin
            inst_t ei;
            checks++;
            if (exp_inst.size() == 0) begin
                errors++;
                $display("FAIL inst_unexpected: got pc %h data %h, none expected", inst_pc, inst_data);
            end else begin
                ei = exp_inst.pop_front();
                if (inst_pc !== ei.pc || inst_data !== ei.data) begin
                    errors++;
                    $display("FAIL inst: got pc %h data %h, expected pc %h data %h",
                             inst_pc, inst_data, ei.pc, ei.data);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            rsp_t r;
            r.due  = cyc + rsp_lat - 1;
            r.data = mem_word(acc_addr) ^ salt;
            rsp_q.push_back(r);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic wait_req(input logic [31:0] a, input int budget);
        bit found = 0;
        checks++;
        for (int i = 0; i < budget && !found; i++) begin
            if (imem_req_valid && imem_req_addr === a) found = 1;
            else tick();
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_req: request for %h never seen, last addr %h", a, imem_req_addr);
        end
    endtask

    // Stalls imem as soon as all expected requests are taken so the
    // sequencer parks in REQ instead of running ahead.
    task automatic wait_drain(input int budget);
        bit done = 0;
        checks++;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (exp_req.size() == 0) imem_req_ready = 1'b0;
            if (exp_req.size() == 0 && exp_inst.size() == 0) done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL drain: %0d requests and %0d instructions outstanding, expected 0",
                     exp_req.size(), exp_inst.size());
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        rsp_lat        = 1;
        salt           = '0;
        exp_req.delete();
        exp_inst.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 5;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b, expected 0", inst_valid); end
        if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data: got %h, expected 0", inst_data); end
        if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h, expected 0", inst_pc); end
        if (imem_req_addr !== 32'h0000_3000) begin errors++; $display("FAIL rst_addr: got %h, expected 00003000", imem_req_addr); end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid: got %b, expected 0", imem_req_valid); end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL first_req: got valid %b addr %h, expected 1 00003000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        push_fetch(32'h3000, 1);
        push_fetch(32'h3004, 1);
        push_fetch(32'h3008, 1);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_drain(100);
    endtask

    task automatic test_req_stall();
        do_reset();
        push_fetch(32'h3000, 1);
        push_fetch(32'h3004, 1);
        inst_ready = 1'b1;
        wait_req(32'h3000, 10);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        wait_req(32'h3004, 20);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3004) begin
                errors++;
                $display("FAIL req_hold: got valid %b addr %h, expected 1 00003004", imem_req_valid, imem_req_addr);
            end
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        wait_drain(50);
    endtask

    task automatic test_out_stall();
        bit seen = 0;
        do_reset();
        push_fetch(32'h3000, 1);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (inst_valid) seen = 1;
        end
        imem_req_ready = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL out_reach: inst_valid never rose, expected 1"); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 || inst_data !== mem_word(32'h3000) || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL out_hold: got v %b pc %h data %h req %b, expected 1 00003000 %h 0",
                         inst_valid, inst_pc, inst_data, imem_req_valid, mem_word(32'h3000));
            end
        end
        inst_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        rsp_lat = 2;
        push_fetch(32'h3000, 1);
        push_fetch(32'h3004, 0);
        push_fetch(32'h4000, 1);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_req(32'h3004, 30);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h4002;
        tick();
        redirect_valid = 1'b0;
        wait_drain(50);
    endtask

    task automatic test_redirect_hs();
        do_reset();
        push_fetch(32'h3000, 1);
        push_fetch(32'h3004, 0);
        push_fetch(32'h5000, 1);
        push_fetch(32'h5004, 0);
        push_fetch(32'h6000, 1);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_req(32'h3004, 30);
        redirect_valid  = 1'b1;
        redirect_target = 32'h5000;
        tick();
        redirect_valid = 1'b0;
        wait_req(32'h5004, 30);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h6000;
        tick();
        redirect_valid = 1'b0;
        wait_drain(50);
    endtask

    task automatic test_reset_midwait();
        do_reset();
        rsp_lat = 3;
        salt    = 32'hBAD0_BAD0;
        exp_req.push_back(32'h3000);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_req(32'h3000, 10);
        tick();
        salt = '0;
        rst  = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h3000) begin
            errors++;
            $display("FAIL midwait_rst: got v %b req %b addr %h, expected 0 0 00003000",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        rst = 1'b0;
        push_fetch(32'h3000, 1);
        wait_drain(50);
    endtask

    task automatic test_wrap();
        do_reset();
        wait_req(32'h3000, 10);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL withdraw: got valid %b addr %h, expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        push_fetch(32'hFFFF_FFFC, 1);
        push_fetch(32'h0000_0000, 1);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_drain(50);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_req_stall();
        test_out_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_reset_midwait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
